// File: rtl/fw_interface_regs_if.sv
// Wishbone slave bus bundle for the firmware-interface register block.
interface fw_interface_regs_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/fw_interface_regs.sv
// Wishbone register block feeding the firmware-interface test logic: value registers,
// string byte bus and new_* notification pulses. Optional macro: FW_INTERFACE_OVERFLOW_ERR_EN.
module fw_interface_regs #(
  parameter int unsigned STR_DEPTH    = 32,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  fw_interface_regs_if.slave  bus,
  output logic                new_report,
  output logic                new_warning,
  output logic                new_error,
  output logic                new_compare,
  output logic [31:0]         report_reg,
  output logic [31:0]         warning_reg,
  output logic [31:0]         error_reg,
  output logic [31:0]         expected_reg,
  output logic [31:0]         measured_reg,
  output logic [5:0]          index,
  output logic [7:0]          data,
  output logic                write_mem
);
  localparam int unsigned PTR_W = 6;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STR_DEPTH - 1);

  typedef enum logic [2:0] {
    REG_REPORT, REG_WARNING, REG_ERROR, REG_COMPARE,
    REG_EXPECTED, REG_MEASURED, REG_STRING, REG_STATUS
  } reg_e;

  logic [PTR_W-1:0] ptr_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [NCH-1:0]   new_q;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      dat_q;

  reg_e             reg_c;
  logic             access_c;
  logic             wr_c;
  logic             ack_set_c;
  logic [NCH-1:0]   trig_c;
  logic             byte_nz_c;
  logic             str_wr_c;
  logic             str_ovf_c;
  logic             clr_c;
  logic [31:0]      rdata_c;
  logic             unused_adr;

  assign unused_adr = ^bus.wb_adr_i[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

  // Access decode, string pointer rules and read mux
  always_comb begin
    reg_c     = reg_e'(bus.wb_adr_i[4:2]);
    access_c  = bus.wb_cyc_i && bus.wb_stb_i && !ack_q && !err_q;
    wr_c      = access_c && bus.wb_we_i;
    trig_c    = '0;
    byte_nz_c = (bus.wb_dat_i[7:0] != 8'h00);
    str_wr_c  = wr_c && (reg_c == REG_STRING) && bus.wb_sel_i[0];
    str_ovf_c = str_wr_c && (ptr_q == PTR_LAST) && byte_nz_c;
    rdata_c   = '0;
    if (wr_c) begin
      case (reg_c)
        REG_REPORT:  trig_c[0] = 1'b1;
        REG_WARNING: trig_c[1] = 1'b1;
        REG_ERROR:   trig_c[2] = 1'b1;
        REG_COMPARE: trig_c[3] = 1'b1;
        default:     trig_c    = '0;
      endcase
    end
    // End of a REPORT pulse rewinds the string so the next message starts at 0
    clr_c = ((cnt_q[0] == CNT_W'(1)) && !trig_c[0])
         || (wr_c && (reg_c == REG_STATUS) && bus.wb_dat_i[0]);
    case (reg_c)
      REG_REPORT:   rdata_c = report_reg;
      REG_WARNING:  rdata_c = warning_reg;
      REG_ERROR:    rdata_c = error_reg;
      REG_EXPECTED: rdata_c = expected_reg;
      REG_MEASURED: rdata_c = measured_reg;
      REG_STATUS:   rdata_c = {19'b0, new_q, ovf_q, 2'b0, ptr_q};
      default:      rdata_c = '0;
    endcase
  end

`ifdef FW_INTERFACE_OVERFLOW_ERR_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else          err_q <= access_c && str_ovf_c;
  end
  assign ack_set_c = access_c && !str_ovf_c;
`else
  assign err_q     = 1'b0;
  assign ack_set_c = access_c;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      report_reg   <= '0;
      warning_reg  <= '0;
      error_reg    <= '0;
      expected_reg <= '0;
      measured_reg <= '0;
      index        <= '0;
      data         <= '0;
      write_mem    <= 1'b0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      new_q        <= '0;
      for (int ch = 0; ch < NCH; ch++) cnt_q[ch] <= '0;
    end else begin
      ack_q     <= ack_set_c;
      dat_q     <= (access_c && !bus.wb_we_i) ? rdata_c : '0;
      write_mem <= 1'b0;

      if (wr_c) begin
        case (reg_c)
          REG_REPORT:   report_reg   <= merge_bytes(report_reg,   bus.wb_dat_i, bus.wb_sel_i);
          REG_WARNING:  warning_reg  <= merge_bytes(warning_reg,  bus.wb_dat_i, bus.wb_sel_i);
          REG_ERROR:    error_reg    <= merge_bytes(error_reg,    bus.wb_dat_i, bus.wb_sel_i);
          REG_EXPECTED: expected_reg <= merge_bytes(expected_reg, bus.wb_dat_i, bus.wb_sel_i);
          REG_MEASURED: measured_reg <= merge_bytes(measured_reg, bus.wb_dat_i, bus.wb_sel_i);
          default: ;
        endcase
      end

      // Level is registered from the counter so it rises one cycle after the ack edge
      for (int ch = 0; ch < NCH; ch++) begin
        new_q[ch] <= (cnt_q[ch] != '0);
        if (trig_c[ch])              cnt_q[ch] <= CNT_W'(PULSE_CYCLES);
        else if (cnt_q[ch] != '0)    cnt_q[ch] <= cnt_q[ch] - CNT_W'(1);
      end

      if (str_wr_c && !str_ovf_c) begin
        index     <= ptr_q;
        data      <= bus.wb_dat_i[7:0];
        write_mem <= 1'b1;
      end

      if (clr_c) begin
        ptr_q <= '0;
        ovf_q <= 1'b0;
      end else if (str_ovf_c) begin
        ovf_q <= 1'b1;
      end else if (str_wr_c) begin
        ptr_q <= byte_nz_c ? ptr_q + PTR_W'(1) : '0;
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_dat_o = dat_q;
  assign new_report   = new_q[0];
  assign new_warning  = new_q[1];
  assign new_error    = new_q[2];
  assign new_compare  = new_q[3];
endmodule
